uart_message_parser: RTL

Converts the byte stream from the UART receiver into register-bus requests for the manta cores. Sits between `uart_rx` (upstream, one byte per `valid_i` pulse) and the core chain (downstream), which receives a single-cycle request carrying address, write data and direction. Decodes ASCII hex read/write messages. Malformed messages are dropped silently, with no request issued.

---
 rtl/uart_message_parser.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_message_parser.sv
// Decodes ASCII hex read/write messages ("Raaaa<CR>", "Waaaadddd<LF>") from a UART byte
// stream into single-cycle register-bus requests. Malformed messages are dropped silently.
module uart_message_parser #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rw_o,
    output logic                  valid_o
);

    localparam int ADDR_DIGITS = ADDR_WIDTH / 4;
    localparam int DATA_DIGITS = DATA_WIDTH / 4;
    localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int CNT_WIDTH   = $clog2(MAX_DIGITS + 1);

    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_DIGITS - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        TERM
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_buf_q, addr_buf_d;
    logic [DATA_WIDTH-1:0] data_buf_q, data_buf_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rw_q, rw_d;
    logic                  valid_q, valid_d;

    logic       is_digit, is_upper, is_lower, is_hex, is_term, is_read, is_write;
    logic [3:0] nibble;

    // Letters 'A'-'F' and 'a'-'f' share low nibbles 1..6, so +9 yields 10..15 for both cases.
    always_comb begin
        is_digit = (data_i >= 8'h30) && (data_i <= 8'h39);
        is_upper = (data_i >= 8'h41) && (data_i <= 8'h46);
        is_lower = (data_i >= 8'h61) && (data_i <= 8'h66);
        is_hex   = is_digit || is_upper || is_lower;
        nibble   = is_digit ? data_i[3:0] : data_i[3:0] + 4'd9;
        is_term  = (data_i == 8'h0D) || (data_i == 8'h0A);
        is_read  = (data_i == 8'h52) || (data_i == 8'h72);
        is_write = (data_i == 8'h57) || (data_i == 8'h77);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        addr_buf_d = addr_buf_q;
        data_buf_d = data_buf_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rw_d       = rw_q;
        valid_d    = 1'b0;

        if (valid_i) begin
            unique case (state_q)
                IDLE: begin
                    if (is_read || is_write) begin
                        state_d    = ADDR;
                        wr_d       = is_write;
                        addr_buf_d = '0;
                        data_buf_d = '0;
                        cnt_d      = '0;
                    end
                end
                ADDR: begin
                    if (is_hex) begin
                        addr_buf_d = (addr_buf_q << 4) | ADDR_WIDTH'(nibble);
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d   = '0;
                            state_d = wr_q ? DATA : TERM;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (is_hex) begin
                        data_buf_d = (data_buf_q << 4) | DATA_WIDTH'(nibble);
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            state_d = TERM;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                TERM: begin
                    // Any byte leaves TERM; only a terminator turns the message into a request.
                    state_d = IDLE;
                    if (is_term) begin
                        valid_d = 1'b1;
                        addr_d  = addr_buf_q;
                        data_d  = wr_q ? data_buf_q : '0;
                        rw_d    = wr_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_buf_q <= '0;
            data_buf_q <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rw_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            addr_buf_q <= addr_buf_d;
            data_buf_q <= data_buf_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
            valid_q    <= valid_d;
        end
    end

    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;

endmodule
